lf_addsub_pipe: RTL and testbench

- Pipelined, elastic add/subtract unit built on the team's Ladner-Fischer prefix levels; it is the complement of the adder-only prefix datapath.
- Computes a+b or a−b (as a+~b+1) through a log2(WIDTH)-level prefix tree, split across three register stages.
- Uses valid/ready handshakes on both sides and emits carry/borrow, signed overflow and zero flags.
- Sits between the operand-issue logic and the writeback stage of the datapath.

---
 rtl/lf_addsub_pipe.sv | 130 +++++++++++++
 tb/tb_lf_addsub_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lf_addsub_pipe.sv
// Elastic three-stage add/subtract unit on a Ladner-Fischer prefix tree.
// A global advance enable moves all stages together and emits carry/borrow, overflow and zero flags.
module lf_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cb,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int L   = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    // Group generate after prefix level k. Bit i joins with the top bit of the adjacent lower group.
    function automatic logic [WIDTH-1:0] level_g(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] p,
                                                 input int k);
        logic [WIDTH-1:0] r;
        logic [L-1:0]     ii;
        logic [L-1:0]     jj;
        r = g;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> (k - 1)) & 1) == 1) begin
                ii    = L'(i);
                jj    = L'(((i >> k) << k) + (1 << (k - 1)) - 1);
                r[ii] = g[ii] | (p[ii] & g[jj]);
            end
        end
        return r;
    endfunction

    // Group propagate. Spans that reach bit 0 use grey cells and are already resolved, so their P is not updated.
    function automatic logic [WIDTH-1:0] level_p(input logic [WIDTH-1:0] p,
                                                 input int k);
        logic [WIDTH-1:0] r;
        logic [L-1:0]     ii;
        logic [L-1:0]     jj;
        r = p;
        for (int i = 0; i < WIDTH; i++) begin
            if ((((i >> (k - 1)) & 1) == 1) && (i >= (1 << k))) begin
                ii    = L'(i);
                jj    = L'(((i >> k) << k) + (1 << (k - 1)) - 1);
                r[ii] = p[ii] & p[jj];
            end
        end
        return r;
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [MSB:0] b_eff, p0, g0, s1_g_d, s1_p_d;
    always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        p0     = in_a ^ b_eff;
        g0     = in_a & b_eff;
        g0[0]  = g0[0] | (p0[0] & in_sub);
        s1_g_d = level_g(g0, p0, 1);
        s1_p_d = level_p(p0, 1);
    end

    logic         s1_valid, s1_sub, s1_amsb, s1_bmsb;
    logic [MSB:0] s1_g, s1_p, s1_pb;
    logic         s2_valid, s2_sub, s2_amsb, s2_bmsb;
    logic [MSB:0] s2_g, s2_p, s2_pb;
    logic [MSB:0] s2_g_d, s2_p_d, g_tmp;

    always_comb begin
        s2_g_d = s1_g;
        s2_p_d = s1_p;
        g_tmp  = s1_g;
        for (int k = 2; k < L; k++) begin
            g_tmp  = level_g(s2_g_d, s2_p_d, k);
            s2_p_d = level_p(s2_p_d, k);
            s2_g_d = g_tmp;
        end
    end

    logic [MSB:0] g_fin, sum_d;
    logic         cout;
    always_comb begin
        g_fin = level_g(s2_g, s2_p, L);
        sum_d = s2_pb ^ {g_fin[MSB-1:0], s2_sub};
        cout  = g_fin[MSB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cb    <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_g      <= s1_g_d;
            s1_p      <= s1_p_d;
            s1_pb     <= p0;
            s1_sub    <= in_sub;
            s1_amsb   <= in_a[MSB];
            s1_bmsb   <= b_eff[MSB];

            s2_valid  <= s1_valid;
            s2_g      <= s2_g_d;
            s2_p      <= s2_p_d;
            s2_pb     <= s1_pb;
            s2_sub    <= s1_sub;
            s2_amsb   <= s1_amsb;
            s2_bmsb   <= s1_bmsb;

            out_valid <= s2_valid;
            out_sum   <= sum_d;
            out_cb    <= s2_sub ? ~cout : cout;
            out_ovf   <= (s2_amsb == s2_bmsb) & (sum_d[MSB] != s2_amsb);
            out_zero  <= (sum_d == '0);
        end
    end
endmodule

// File: tb/tb_lf_addsub_pipe.sv
// Bench for lf_addsub_pipe: an arithmetic reference model with an in-order scoreboard.
// It also runs directed corner cases, stall, and reset-flush scenarios.
module tb_lf_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_cb, out_ovf, out_zero;
    logic [15:0] in_a, in_b, out_sum;

    int checks   = 0;
    int failures = 0;

    logic [18:0] exp_q[$];
    logic [18:0] held;
    logic [18:0] dut_res;
    bit          stall_prev = 1'b0;

    lf_addsub_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cb(out_cb), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    assign dut_res = {out_sum, out_cb, out_ovf, out_zero};

    // Result layout: {sum[15:0], cb, ovf, zero}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] full;
        logic [15:0] sum;
        logic        cb, ovf;
        int          sa, sb, sr;
        if (s) begin
            sum = a - b;
            cb  = (a < b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            sum  = full[15:0];
            cb   = full[16];
        end
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sr  = s ? sa - sb : sa + sb;
        ovf = (sr > 32767) || (sr < -32768);
        return {sum, cb, ovf, (sum == 16'h0000)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and handshake rules, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(dut_res), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none at %0t", dut_res, $time);
                end else begin
                    check("stream_result", 32'(dut_res), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_sub));
            stall_prev = out_valid && !out_ready;
            held       = dut_res;
        end
    end

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [18:0] lit, input string name);
        check({name, "_model"}, 32'(model(a, b, s)), 32'(lit));
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_dut"}, 32'(dut_res), 32'(lit));
    endtask

    task automatic stream(input int n, input bit toggle);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
        in_valid = 1'b1;
        while (sent < n && cyc < 200) begin
            out_ready = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
                if (sent >= n) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && cyc < 30) begin
            tick();
            cyc++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    logic [18:0] e[3];
    logic [15:0] fa[3], fb[3];
    logic        fs[3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_outs", 32'(dut_res), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        run_one(16'h0000, 16'h0001, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0}, "sub_0_1");
        run_one(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0}, "sub_8000_1");
        run_one(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0}, "add_7fff_1");
        run_one(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}, "add_ffff_1");
        run_one(16'h1234, 16'h1234, 1'b1, {16'h0000, 1'b0, 1'b0, 1'b1}, "sub_equal");
        drain();

        stream(8, 1'b0);
        drain();
        stream(8, 1'b1);
        drain();
        stream(40, 1'b1);
        drain();

        // Fill three beats with the output blocked, then hold for five cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fa[i] = 16'($urandom); fb[i] = 16'($urandom); fs[i] = 1'($urandom);
            e[i]  = model(fa[i], fb[i], fs[i]);
            in_a = fa[i]; in_b = fb[i]; in_sub = fs[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_ready_low", 32'(in_ready), 32'd0);
            check("fill_valid", 32'(out_valid), 32'd1);
            check("fill_hold_first", 32'(dut_res), 32'(e[0]));
            tick();
        end
        out_ready = 1'b1;
        check("release_first", 32'(dut_res), 32'(e[0]));
        tick();
        check("release_second_valid", 32'(out_valid), 32'd1);
        check("release_second", 32'(dut_res), 32'(e[1]));
        tick();
        check("release_third_valid", 32'(out_valid), 32'd1);
        check("release_third", 32'(dut_res), 32'(e[2]));
        tick();
        check("release_empty", 32'(out_valid), 32'd0);
        drain();

        // Reset with two beats in flight and a colliding accept.
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 16'h5555; in_b = 16'h0001; in_sub = 1'b1;
        tick();
        rst = 1'b1;
        in_a = 16'h00AA; in_b = 16'h0055;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_outs", 32'(dut_res), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_no_stale", 32'(out_valid), 32'd0);
        end
        run_one(16'h0003, 16'h0004, 1'b0, {16'h0007, 1'b0, 1'b0, 1'b0}, "post_reset");
        drain();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
